// File: rtl/alu_core.sv
// Registered 32-bit integer ALU: one operation captured per clock edge,
// result and zero/overflow/carry flags held until the next edge.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALU_operation,
  input  logic [4:0]  shamt,
  output logic [31:0] res,
  output logic        zero,
  output logic        overflow,
  output logic        carry
);

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpAddu = 4'd3;
  localparam logic [3:0] OpSub  = 4'd4;
  localparam logic [3:0] OpSubu = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpSltu = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpXor  = 4'd11;
  localparam logic [3:0] OpNor  = 4'd12;
  localparam logic [3:0] OpLui  = 4'd13;

  logic [32:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        borrow;
  logic        slt;
  logic [31:0] res_d;
  logic        overflow_d;
  logic        carry_d;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = A - B;
  assign borrow  = A < B;
  assign add_ovf = ~(A[31] ^ B[31]) & (sum[31] ^ A[31]);
  assign sub_ovf = (A[31] ^ B[31]) & (diff[31] ^ A[31]);
  // Signed less-than: operand signs differ -> A negative wins; else use the unsigned compare.
  assign slt     = (A[31] ^ B[31]) ? A[31] : borrow;

  always_comb begin
    res_d      = 32'h0;
    overflow_d = 1'b0;
    carry_d    = 1'b0;
    case (ALU_operation)
      OpAnd:  res_d = A & B;
      OpOr:   res_d = A | B;
      OpAdd: begin
        res_d      = sum[31:0];
        overflow_d = add_ovf;
        carry_d    = sum[32];
      end
      OpAddu: begin
        res_d   = sum[31:0];
        carry_d = sum[32];
      end
      OpSub: begin
        res_d      = diff;
        overflow_d = sub_ovf;
        carry_d    = borrow;
      end
      OpSubu: begin
        res_d   = diff;
        carry_d = borrow;
      end
      OpSlt:  res_d = {31'h0, slt};
      OpSltu: res_d = {31'h0, borrow};
      OpSll:  res_d = B << shamt;
      OpSrl:  res_d = B >> shamt;
      OpSra:  res_d = $unsigned($signed(B) >>> shamt);
      OpXor:  res_d = A ^ B;
      OpNor:  res_d = ~(A | B);
      OpLui:  res_d = {B[15:0], 16'h0};
      default: begin
        res_d      = 32'h0;
        overflow_d = 1'b0;
        carry_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res      <= 32'h0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      carry    <= 1'b0;
    end else begin
      res      <= res_d;
      zero     <= (res_d == 32'h0);
      overflow <= overflow_d;
      carry    <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: expected results queued when an operation is
// driven, popped and compared one cycle later when the registered result appears.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_operation;
  logic [4:0]  shamt;
  logic [31:0] res;
  logic        zero;
  logic        overflow;
  logic        carry;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ov;
    logic        c;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_core dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .ALU_operation (ALU_operation),
    .shamt         (shamt),
    .res           (res),
    .zero          (zero),
    .overflow      (overflow),
    .carry         (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input logic [31:0] er, input logic ez,
                         input logic eov, input logic ec);
    cmp({tag, ".res"}, res, er);
    cmp({tag, ".zero"}, {31'h0, zero}, {31'h0, ez});
    cmp({tag, ".ovf"}, {31'h0, overflow}, {31'h0, eov});
    cmp({tag, ".carry"}, {31'h0, carry}, {31'h0, ec});
  endtask

  task automatic drive(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                       input logic eov, input logic ec);
    exp_t e;
    @(negedge clk);
    ALU_operation = op;
    A             = a;
    B             = b;
    shamt         = sh;
    e.tag = tag;
    e.res = er;
    e.ov  = eov;
    e.c   = ec;
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = q.pop_front();
      cmp_all(e.tag, e.res, (e.res == 32'h0), e.ov, e.c);
      last = e;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                     input logic eov, input logic ec);
    drive(tag, op, a, b, sh, er, eov, ec);
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    A = '0; B = '0; ALU_operation = '0; shamt = '0;
    #2;
    cmp_all("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cmp_all("reset_hold", 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    run("and",  4'd0, 32'hffff0000, 32'haaaaaaaa, 5'd0, 32'haaaa0000, 1'b0, 1'b0);

    // Latency: new inputs must not reach the outputs before the next edge.
    drive("or", 4'd1, 32'hffff0000, 32'haaaaaaaa, 5'd0, 32'hffffaaaa, 1'b0, 1'b0);
    #1;
    cmp("latency.res", res, last.res);
    check_out();

    run("xor",  4'd11, 32'hffff0000, 32'haaaaaaaa, 5'd0, 32'h5555aaaa, 1'b0, 1'b0);
    run("nor",  4'd12, 32'hffff0000, 32'haaaaaaaa, 5'd0, 32'h00005555, 1'b0, 1'b0);
    run("lui",  4'd13, 32'h12345678, 32'hdeadbeef, 5'd0, 32'hbeef0000, 1'b0, 1'b0);

    run("add_ovf",    4'd2, 32'h7fffffff, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0);
    run("add_carry",  4'd2, 32'hffffffff, 32'hffffffff, 5'd0, 32'hfffffffe, 1'b0, 1'b1);
    run("add_both",   4'd2, 32'h80000000, 32'hffffffff, 5'd0, 32'h7fffffff, 1'b1, 1'b1);
    run("sub_ovf_b",  4'd4, 32'h7fffffff, 32'hffffffff, 5'd0, 32'h80000000, 1'b1, 1'b1);
    run("sub_ovf",    4'd4, 32'h80000000, 32'h00000001, 5'd0, 32'h7fffffff, 1'b1, 1'b0);
    run("addu_wrap",  4'd3, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b1);
    run("addu_nov",   4'd3, 32'h7fffffff, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b0);
    run("subu_bor",   4'd5, 32'h00000000, 32'h00000001, 5'd0, 32'hffffffff, 1'b0, 1'b1);
    run("subu_nov",   4'd5, 32'h80000000, 32'h00000001, 5'd0, 32'h7fffffff, 1'b0, 1'b0);

    run("slt_m1",     4'd6, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
    run("sltu_m1",    4'd7, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b0);
    run("slt_min",    4'd6, 32'h80000000, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
    run("sltu_min",   4'd7, 32'h80000000, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b0);
    run("slt_pos",    4'd6, 32'h00000005, 32'h00000003, 5'd0, 32'h00000000, 1'b0, 1'b0);

    run("sll1",  4'd8,  32'h12345678, 32'hffffffff, 5'd1,  32'hfffffffe, 1'b0, 1'b0);
    run("sll2",  4'd8,  32'h12345678, 32'hffffffff, 5'd2,  32'hfffffffc, 1'b0, 1'b0);
    run("sll31", 4'd8,  32'h12345678, 32'hffffffff, 5'd31, 32'h80000000, 1'b0, 1'b0);
    run("sll0",  4'd8,  32'hffffffff, 32'h0000abcd, 5'd0,  32'h0000abcd, 1'b0, 1'b0);
    run("srl1",  4'd9,  32'hffffffff, 32'hffff0000, 5'd1,  32'h7fff8000, 1'b0, 1'b0);
    run("srl2",  4'd9,  32'hffffffff, 32'hffff0000, 5'd2,  32'h3fffc000, 1'b0, 1'b0);
    run("srl3",  4'd9,  32'hffffffff, 32'hffff0000, 5'd3,  32'h1fffe000, 1'b0, 1'b0);
    run("sra1",  4'd10, 32'h00000000, 32'hffff0000, 5'd1,  32'hffff8000, 1'b0, 1'b0);
    run("sra2",  4'd10, 32'h00000000, 32'hffff0000, 5'd2,  32'hffffc000, 1'b0, 1'b0);
    run("sra3",  4'd10, 32'h00000000, 32'hffff0000, 5'd3,  32'hffffe000, 1'b0, 1'b0);
    run("sra_pos", 4'd10, 32'hffffffff, 32'h7fff0000, 5'd4, 32'h07fff000, 1'b0, 1'b0);

    run("op14",  4'd14, 32'hffffffff, 32'hffffffff, 5'd3, 32'h00000000, 1'b0, 1'b0);
    run("op15",  4'd15, 32'h7fffffff, 32'h00000001, 5'd3, 32'h00000000, 1'b0, 1'b0);

    // Leave nonzero state with flags set, then reset between edges.
    run("pre_rst", 4'd2, 32'h80000000, 32'hffffffff, 5'd0, 32'h7fffffff, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmp_all("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cmp_all("rst_held", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 4'd1, 32'h0000f0f0, 32'h0f0f0000, 5'd0, 32'h0f0ff0f0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
